// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and constants for the alarm sequencer
// Purpose: state encoding, state width and timer blanking length used by
//          the sequencer, its interface and the bench.
// Ports:   none (package).
package alarm_pkg;

  localparam int STATE_W   = 3;
  // Cycles during which tmr_tc is ignored after a reload: the load cycle
  // and the one after it, while the timer still shows the stale count.
  localparam int BLANK_CYC = 2;
  localparam int BLANK_W   = $clog2(BLANK_CYC + 1);

  typedef enum logic [STATE_W-1:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } state_e;

  function automatic logic is_armed(input state_e s);
    return (s == ST_ARMED) || (s == ST_ENTRY) || (s == ST_ALARM);
  endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// rtl/alarm_sequencer_if.sv - keypad/sensor, timer and indicator bundle
// Purpose: groups the sequencer's non-clock signals.
// Ports:   master = sequencer side (consumes requests/tmr_tc, drives timer
//          controls and indicators); slave = environment side.
interface alarm_sequencer_if;
  import alarm_pkg::*;

  logic               arm_req;
  logic               disarm_req;
  logic               sensor;
  logic               tmr_tc;
  logic               tmr_en;
  logic               tmr_load;
  logic               armed;
  logic               siren;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  arm_req, disarm_req, sensor, tmr_tc,
    output tmr_en, tmr_load, armed, siren, state_o
  );

  modport slave (
    output arm_req, disarm_req, sensor, tmr_tc,
    input  tmr_en, tmr_load, armed, siren, state_o
  );

endinterface

// File: rtl/alarm_sequencer_sync_edge.sv
// rtl/alarm_sequencer_sync_edge.sv - input synchroniser with rise detector
// Purpose: brings an asynchronous level into the clock domain and produces
//          a one-cycle pulse one cycle after the synchronised level rises.
// Ports:   clk_i, rst_ni (async active-low), d_i async level,
//          level_o synchronised level, rise_o registered rising-edge pulse.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = rise_q;

endmodule

// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - alarm control FSM driving the ten-second timer
// Purpose: sequences DISARMED -> EXIT -> ARMED -> ENTRY -> ALARM, starts the
//          timer on entering EXIT/ENTRY and drives armed/siren indicators.
//          Optional macro ALARM_AUTO_REARM_EN: ALARM keeps the timer running
//          and returns to ARMED after ALARM_TIMEOUTS expiries.
// Ports:   clock50 system clock, Mr async active-low master reset,
//          bus (alarm_sequencer_if.master): arm_req/disarm_req/sensor async
//          levels, tmr_tc timer terminal count, tmr_en/tmr_load timer
//          controls, armed/siren indicators, state_o current state.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int ALARM_TIMEOUTS = 18,
  parameter int CNT_W          = 5
) (
  input  logic               clock50,
  input  logic               Mr,
  alarm_sequencer_if.master  bus
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if ((2 ** CNT_W) <= ALARM_TIMEOUTS) begin : g_bad_cnt
    $error("CNT_W too narrow for ALARM_TIMEOUTS");
  end

  logic arm_lvl_unused, arm_rise;
  logic dis_lvl_unused, dis_rise;
  logic sensor_lvl, sensor_rise_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_arm (
    .clk_i(clock50), .rst_ni(Mr), .d_i(bus.arm_req),
    .level_o(arm_lvl_unused), .rise_o(arm_rise)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_disarm (
    .clk_i(clock50), .rst_ni(Mr), .d_i(bus.disarm_req),
    .level_o(dis_lvl_unused), .rise_o(dis_rise)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sensor (
    .clk_i(clock50), .rst_ni(Mr), .d_i(bus.sensor),
    .level_o(sensor_lvl), .rise_o(sensor_rise_unused)
  );

  state_e               state_q, state_d;
  logic                 tmr_en_q, tmr_en_d;
  logic                 tmr_load_q, tmr_load_d;
  logic                 armed_q, siren_q;
  logic [BLANK_W-1:0]   blank_q, blank_d;
  logic                 expiry;

  // A terminal count only counts once the reloaded timer has had time to
  // clear its stale tc from the previous interval.
  assign expiry = tmr_en_q && bus.tmr_tc && (blank_q == '0);

`ifdef ALARM_AUTO_REARM_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_expiry;

  assign last_expiry = (cnt_q == CNT_W'(ALARM_TIMEOUTS - 1));
`endif

  always_comb begin
    state_d    = state_q;
    tmr_load_d = 1'b0;

    // Disarm beats every other event, including a simultaneous arm.
    if (dis_rise) begin
      state_d = ST_DISARMED;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          if (arm_rise) begin
            state_d    = ST_EXIT;
            tmr_load_d = 1'b1;
          end
        end
        ST_EXIT: begin
          if (expiry) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (sensor_lvl) begin
            state_d    = ST_ENTRY;
            tmr_load_d = 1'b1;
          end
        end
        ST_ENTRY: begin
          if (expiry) begin
            state_d = ST_ALARM;
`ifdef ALARM_AUTO_REARM_EN
            tmr_load_d = 1'b1;
`endif
          end
        end
        ST_ALARM: begin
`ifdef ALARM_AUTO_REARM_EN
          if (expiry) begin
            if (last_expiry) state_d = ST_ARMED;
            else             tmr_load_d = 1'b1;
          end
`else
          state_d = ST_ALARM;
`endif
        end
        default: state_d = ST_DISARMED;
      endcase
    end

    tmr_en_d = (state_d == ST_EXIT) || (state_d == ST_ENTRY);
`ifdef ALARM_AUTO_REARM_EN
    if (state_d == ST_ALARM) tmr_en_d = 1'b1;
`endif

    if (tmr_load_d)          blank_d = BLANK_W'(BLANK_CYC);
    else if (blank_q != '0)  blank_d = blank_q - BLANK_W'(1);
    else                     blank_d = '0;

`ifdef ALARM_AUTO_REARM_EN
    // Counter lives only while in ALARM; any exit clears it.
    cnt_d = '0;
    if (state_d == ST_ALARM) begin
      if ((state_q == ST_ALARM) && expiry) cnt_d = cnt_q + CNT_W'(1);
      else                                 cnt_d = cnt_q;
    end
`endif
  end

  always_ff @(posedge clock50 or negedge Mr) begin
    if (!Mr) begin
      state_q    <= ST_DISARMED;
      tmr_en_q   <= 1'b0;
      tmr_load_q <= 1'b0;
      armed_q    <= 1'b0;
      siren_q    <= 1'b0;
      blank_q    <= '0;
    end else begin
      state_q    <= state_d;
      tmr_en_q   <= tmr_en_d;
      tmr_load_q <= tmr_load_d;
      armed_q    <= is_armed(state_d);
      siren_q    <= (state_d == ST_ALARM);
      blank_q    <= blank_d;
    end
  end

`ifdef ALARM_AUTO_REARM_EN
  always_ff @(posedge clock50 or negedge Mr) begin
    if (!Mr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign bus.tmr_en   = tmr_en_q;
  assign bus.tmr_load = tmr_load_q;
  assign bus.armed    = armed_q;
  assign bus.siren    = siren_q;
  assign bus.state_o  = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - directed self-checking bench for alarm_sequencer
module tb_alarm_sequencer;
  import alarm_pkg::*;

`ifdef ALARM_AUTO_REARM_EN
  localparam logic EXP_ALARM_EN = 1'b1;
`else
  localparam logic EXP_ALARM_EN = 1'b0;
`endif

  logic clk;
  logic mr;
  int   checks;
  int   passed_n;

  alarm_sequencer_if bus ();

  alarm_sequencer #(
    .SYNC_STAGES(2),
    .ALARM_TIMEOUTS(3),
    .CNT_W(5)
  ) dut (
    .clock50(clk),
    .Mr(mr),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed_n++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    checks = 0;
    passed_n = 0;
    mr = 1'b0;
    bus.arm_req = 1'b0;
    bus.disarm_req = 1'b0;
    bus.sensor = 1'b0;
    bus.tmr_tc = 1'b0;

    // Reset state
    tick(2);
    chk("rst_state", 32'(bus.state_o), 0);
    chk("rst_tmr_en", 32'(bus.tmr_en), 0);
    chk("rst_armed", 32'(bus.armed), 0);
    mr = 1'b1;
    tick(1);
    chk("post_rst_state", 32'(bus.state_o), 0);

    // Arm: load pulse four edges after the input change, tc blanked
    bus.arm_req = 1'b1;
    tick(3);
    chk("arm_latency_load", 32'(bus.tmr_load), 0);
    chk("arm_latency_state", 32'(bus.state_o), 0);
    tick(1);
    chk("arm_load", 32'(bus.tmr_load), 1);
    chk("arm_state", 32'(bus.state_o), 1);
    chk("arm_tmr_en", 32'(bus.tmr_en), 1);
    bus.tmr_tc = 1'b1;
    bus.arm_req = 1'b0;
    tick(1);
    chk("load_one_cycle", 32'(bus.tmr_load), 0);
    tick(1);
    chk("blank_state", 32'(bus.state_o), 1);
    bus.tmr_tc = 1'b0;
    tick(2);
    chk("exit_hold", 32'(bus.state_o), 1);
    bus.tmr_tc = 1'b1;
    tick(1);
    bus.tmr_tc = 1'b0;
    chk("exit_expiry_state", 32'(bus.state_o), 2);
    chk("exit_expiry_armed", 32'(bus.armed), 1);
    chk("exit_expiry_tmr_en", 32'(bus.tmr_en), 0);

    // Arm edge ignored outside DISARMED
    bus.arm_req = 1'b1;
    tick(5);
    chk("arm_ignored", 32'(bus.state_o), 2);
    bus.arm_req = 1'b0;
    tick(3);

    // Sensor trip, then expiry into ALARM
    bus.sensor = 1'b1;
    tick(2);
    chk("sensor_sync_delay", 32'(bus.state_o), 2);
    tick(1);
    chk("entry_state", 32'(bus.state_o), 3);
    chk("entry_load", 32'(bus.tmr_load), 1);
    bus.sensor = 1'b0;
    tick(2);
    bus.tmr_tc = 1'b1;
    tick(1);
    bus.tmr_tc = 1'b0;
    chk("alarm_state", 32'(bus.state_o), 4);
    chk("alarm_siren", 32'(bus.siren), 1);
    chk("alarm_tmr_en", 32'(bus.tmr_en), 32'(EXP_ALARM_EN));

`ifdef ALARM_AUTO_REARM_EN
    chk("alarm_entry_load", 32'(bus.tmr_load), 1);
    tick(2);
    for (int i = 0; i < 2; i++) begin
      bus.tmr_tc = 1'b1;
      tick(1);
      bus.tmr_tc = 1'b0;
      chk("rearm_reload", 32'(bus.tmr_load), 1);
      chk("rearm_still_alarm", 32'(bus.state_o), 4);
      tick(2);
    end
    bus.tmr_tc = 1'b1;
    tick(1);
    bus.tmr_tc = 1'b0;
    chk("rearm_state", 32'(bus.state_o), 2);
    chk("rearm_siren", 32'(bus.siren), 0);
    chk("rearm_tmr_en", 32'(bus.tmr_en), 0);
    bus.sensor = 1'b1;
    tick(3);
    bus.sensor = 1'b0;
    chk("rearm_entry", 32'(bus.state_o), 3);
    tick(2);
    bus.tmr_tc = 1'b1;
    tick(1);
    bus.tmr_tc = 1'b0;
    chk("rearm_alarm2", 32'(bus.state_o), 4);
    tick(2);
    for (int i = 0; i < 2; i++) begin
      bus.tmr_tc = 1'b1;
      tick(1);
      bus.tmr_tc = 1'b0;
      tick(2);
    end
    chk("two_exp_still_alarm", 32'(bus.state_o), 4);
    bus.disarm_req = 1'b1;
    tick(4);
    chk("rearm_disarm_state", 32'(bus.state_o), 0);
    chk("rearm_disarm_cnt", 32'(dut.cnt_q), 0);
    bus.disarm_req = 1'b0;
    tick(3);
`else
    bus.tmr_tc = 1'b1;
    tick(4);
    bus.tmr_tc = 1'b0;
    chk("alarm_hold", 32'(bus.state_o), 4);
    chk("alarm_hold_tmr_en", 32'(bus.tmr_en), 0);
    bus.disarm_req = 1'b1;
    tick(3);
    chk("disarm_latency", 32'(bus.state_o), 4);
    tick(1);
    chk("disarm_state", 32'(bus.state_o), 0);
    chk("disarm_siren", 32'(bus.siren), 0);
    chk("disarm_armed", 32'(bus.armed), 0);
    bus.disarm_req = 1'b0;
    tick(3);
`endif

    // Disarm priority over expiry in ENTRY
    bus.arm_req = 1'b1;
    tick(4);
    bus.arm_req = 1'b0;
    chk("rearm_exit", 32'(bus.state_o), 1);
    tick(2);
    bus.tmr_tc = 1'b1;
    tick(1);
    bus.tmr_tc = 1'b0;
    chk("rearm_armed", 32'(bus.state_o), 2);
    bus.sensor = 1'b1;
    tick(3);
    bus.sensor = 1'b0;
    chk("prio_entry", 32'(bus.state_o), 3);
    bus.disarm_req = 1'b1;
    tick(3);
    bus.tmr_tc = 1'b1;
    tick(1);
    bus.tmr_tc = 1'b0;
    chk("prio_state", 32'(bus.state_o), 0);
    chk("prio_siren", 32'(bus.siren), 0);
    chk("prio_tmr_en", 32'(bus.tmr_en), 0);
    bus.disarm_req = 1'b0;
    tick(3);

    // Arm and disarm together in DISARMED
    bus.arm_req = 1'b1;
    bus.disarm_req = 1'b1;
    tick(4);
    chk("both_state", 32'(bus.state_o), 0);
    chk("both_load", 32'(bus.tmr_load), 0);
    tick(2);
    chk("both_state_late", 32'(bus.state_o), 0);
    bus.arm_req = 1'b0;
    bus.disarm_req = 1'b0;
    tick(3);

    // Sensor held high through EXIT: ARMED then ENTRY next cycle
    bus.arm_req = 1'b1;
    tick(4);
    bus.arm_req = 1'b0;
    bus.sensor = 1'b1;
    chk("held_exit", 32'(bus.state_o), 1);
    tick(2);
    bus.tmr_tc = 1'b1;
    tick(1);
    bus.tmr_tc = 1'b0;
    chk("held_armed", 32'(bus.state_o), 2);
    tick(1);
    chk("held_entry", 32'(bus.state_o), 3);
    chk("held_entry_load", 32'(bus.tmr_load), 1);
    bus.sensor = 1'b0;

    // Illegal state recovers to DISARMED
    tick(1);
    force dut.state_q = state_e'(3'd6);
    #1;
    release dut.state_q;
    tick(1);
    chk("illegal_state", 32'(bus.state_o), 0);
    chk("illegal_armed", 32'(bus.armed), 0);
    chk("illegal_tmr_en", 32'(bus.tmr_en), 0);
    chk("illegal_siren", 32'(bus.siren), 0);
    tick(3);

    // Asynchronous reset mid-EXIT
    bus.arm_req = 1'b1;
    tick(4);
    bus.arm_req = 1'b0;
    chk("pre_rst_state", 32'(bus.state_o), 1);
    chk("pre_rst_tmr_en", 32'(bus.tmr_en), 1);
    #2;
    mr = 1'b0;
    #1;
    chk("async_rst_state", 32'(bus.state_o), 0);
    chk("async_rst_tmr_en", 32'(bus.tmr_en), 0);
    chk("async_rst_load", 32'(bus.tmr_load), 0);
    chk("async_rst_armed", 32'(bus.armed), 0);
    chk("async_rst_siren", 32'(bus.siren), 0);
    @(negedge clk);
    mr = 1'b1;
    tick(1);
    chk("rst_release_state", 32'(bus.state_o), 0);
    tick(4);
    chk("rst_no_spurious_arm", 32'(bus.state_o), 0);

    $display("%0d/%0d checks passed", passed_n, checks);
    $finish;
  end

endmodule
